// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and default sizes for the instruction-memory arbiter.
//   mode_e  : BOOT (loader-only), DRAIN (one quiet handover cycle), RUN (shared)
//   owner_e : who owns the SRAM response arriving next cycle
package imem_arb_pkg;

  localparam int IMEM_ADDR_WIDTH = 12;
  localparam int IMEM_MAX_WAIT   = 8;
  localparam int WORD_AW         = IMEM_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {BOOT, DRAIN, RUN} mode_e;
  typedef enum logic [1:0] {NONE, IF, LD_RD, LD_WR} owner_e;

  // Counter width able to hold 0..max (at least one bit).
  function automatic int cnt_width(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/imem_arb_age_cnt.sv
// imem_arb_age_cnt: saturating count of cycles the loader has been denied.
//   clk, rst_n : clock, async active-low reset
//   inc        : loader denied this cycle
//   clr        : loader granted, or mode falling back to BOOT (wins over inc)
//   sat        : count has reached MAX_WAIT
module imem_arb_age_cnt
  import imem_arb_pkg::*;
#(
  parameter int MAX_WAIT = IMEM_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = cnt_width(MAX_WAIT);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (inc && !sat)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction SRAM between the fetch port
// (read-only) and the boot/debug loader (read/write). One access per cycle,
// 1-cycle read latency routed back to whoever was granted.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_boot_mode               : 1 = loader-only mode
//   i_if_*, o_if_*            : fetch req/addr, grant, rvalid/rdata
//   i_ld_*, o_ld_*            : loader req/we/be/addr/wdata, grant, rvalid/rdata
//   o_sram_cen/gwen/wen/a/d   : SRAM macro drive (active-low enables)
//   i_sram_q                  : SRAM read data, valid the cycle after access
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int MAX_WAIT   = IMEM_MAX_WAIT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_boot_mode,
  input  logic                  i_if_req,
  input  logic [31:0]           i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [31:0]           o_if_rdata,
  input  logic                  i_ld_req,
  input  logic                  i_ld_we,
  input  logic [3:0]            i_ld_be,
  input  logic [31:0]           i_ld_addr,
  input  logic [31:0]           i_ld_wdata,
  output logic                  o_ld_gnt,
  output logic                  o_ld_rvalid,
  output logic [31:0]           o_ld_rdata,
  output logic                  o_sram_cen,
  output logic                  o_sram_gwen,
  output logic [3:0]            o_sram_wen,
  output logic [ADDR_WIDTH-3:0] o_sram_a,
  output logic [31:0]           o_sram_d,
  input  logic [31:0]           i_sram_q
);

  mode_e  mode;
  owner_e owner;
  logic   if_gnt, ld_gnt;
  logic   age_sat, age_inc, age_clr;

  // Upper bits alias; low two bits are byte offset within the word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[31:ADDR_WIDTH], i_if_addr[1:0],
                              i_ld_addr[31:ADDR_WIDTH], i_ld_addr[1:0]};

  // Grants: combinational from requests and registered mode. Held low while
  // reset is asserted so the port looks idle during reset.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (i_rst_n) begin
      case (mode)
        BOOT: ld_gnt = i_ld_req;
        RUN: begin
          // Fetch wins contention until the loader has starved MAX_WAIT cycles.
          if (i_ld_req && (!i_if_req || age_sat)) ld_gnt = 1'b1;
          else                                     if_gnt = i_if_req;
        end
        default: ;
      endcase
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_ld_gnt = ld_gnt;

  // Mode handover. DRAIN is a single grant-free cycle between BOOT and RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mode <= BOOT;
    else begin
      case (mode)
        BOOT:    if (!i_boot_mode) mode <= DRAIN;
        DRAIN:   mode <= i_boot_mode ? BOOT : RUN;
        RUN:     if (i_boot_mode)  mode <= BOOT;
        default: mode <= BOOT;
      endcase
    end
  end

  // Age only accumulates in RUN; any fall back to BOOT restarts it.
  assign age_inc = (mode == RUN) && i_ld_req && !ld_gnt;
  assign age_clr = ld_gnt || ((mode != BOOT) && i_boot_mode);

  imem_arb_age_cnt #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (age_inc),
    .clr   (age_clr),
    .sat   (age_sat)
  );

  // SRAM drive in the grant cycle; idle keeps every pin at its reset value.
  always_comb begin
    o_sram_cen  = 1'b1;
    o_sram_gwen = 1'b1;
    o_sram_wen  = 4'hF;
    o_sram_a    = '0;
    o_sram_d    = '0;
    if (if_gnt) begin
      o_sram_cen = 1'b0;
      o_sram_a   = i_if_addr[ADDR_WIDTH-1:2];
    end else if (ld_gnt) begin
      o_sram_cen = 1'b0;
      o_sram_a   = i_ld_addr[ADDR_WIDTH-1:2];
      if (i_ld_we) begin
        // be == 0 still issues a (no-op) write so it gets acked like any other.
        o_sram_gwen = 1'b0;
        o_sram_wen  = ~i_ld_be;
        o_sram_d    = i_ld_wdata;
      end
    end
  end

  // Owner of the response arriving next cycle; reset drops any in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    owner <= NONE;
    else if (if_gnt) owner <= IF;
    else if (ld_gnt) owner <= i_ld_we ? LD_WR : LD_RD;
    else             owner <= NONE;
  end

  assign o_if_rvalid = (owner == IF);
  assign o_if_rdata  = (owner == IF) ? i_sram_q : '0;
  assign o_ld_rvalid = (owner == LD_RD) || (owner == LD_WR);
  assign o_ld_rdata  = (owner == LD_RD) ? i_sram_q : '0;

endmodule
